pdm_dac: RTL
============

# pdm_dac

Stereo second-order delta-sigma modulator that turns the mixed 24-bit audio samples (the same left/right words and `next_sample` strobe that feed the I2S DAC interface) into two 1-bit pulse-density outputs. It serves boards without an I2S DAC, where an RC low-pass filter on each pin recovers analog audio. It sits alongside the I2S interface, downstream of the audio mixer, and runs entirely in the system clock domain.

## Interface
- `DIV`, default 1: modulator update period in `clk` cycles (1..256); update rate = f_clk / DIV.
- `rst`  in  1  synchronous, active-high reset.
- `clk`  in  1  system clock; the only clock.
- `enable`  in  1  1 = modulate; 0 = integrators cleared, outputs held low.
- `next_sample`  in  1  one-cycle strobe; latch `left_data`/`right_data` this cycle.
- `left_data`  in  24  signed two's-complement left sample; bits [23:8] are used.
- `right_data`  in  24  signed right sample; bits [23:8] are used.
- `pdm_left`  out  1  registered left PDM bit.
- `pdm_right`  out  1  registered right PDM bit.

## Operation
- Sample latch: on `next_sample`=1, `x_l <= left_data[23:8]` and `x_r <= right_data[23:8]` (signed 16). Held otherwise (zero-order hold). Reset value 0.
- Tick: `div_cnt` counts 0..DIV-1 and wraps; `tick` = (`div_cnt` == DIV-1). With DIV=1, `tick` is 1 every cycle.
- Per channel, on `tick` with `enable`=1:
  - fb = `pdm` ? +32768 : -32768 (signed 18), using the current registered output.
  - `i1_new` = sat20(`i1` + x - fb), with `i1` signed 20 bits.
  - `i2_new` = sat24(`i2` + `i1_new` - fb), with `i2` signed 24 bits.
  - `pdm <= (i2_new >= 0)`.
  - Intermediates are computed one bit wider. satN clamps to [-2^(N-1), 2^(N-1)-1]; integrators never wrap.
- Steady-state ones density = (x + 32768) / 65536.
- `enable`=0: `i1`, `i2` and `pdm` are forced to 0 every cycle. `div_cnt` keeps running and the sample latch keeps working.
- Both channels use the same `tick` and are updated identically and independently.

## Timing
- Reset: `div_cnt`, `x_l`, `x_r`, `i1`, `i2` = 0; `pdm_left` = `pdm_right` = 0.
- The first `tick` is on the DIV-th cycle after `rst` deasserts, i.e. `div_cnt` == DIV-1.
- Outputs change only on the cycle after a `tick`; latency from tick to pin is 1 cycle.
- A sample latched in cycle n is used by the first `tick` in cycle n+1 or later.
- `next_sample` and `tick` in the same cycle: the tick uses the old x; the new x is used from the next tick onward.
- `next_sample` asserted on consecutive cycles: each strobe overwrites the latch; the last one wins.
- `rst` mid-operation takes priority over everything: all state returns to reset values on the next edge.
- `enable` falling: outputs are 0 on the next cycle. `enable` rising: modulation restarts from zero integrators at the next `tick`.

## Structure
- Shared package `audio_pkg`:
  - constants `PDM_IN_W`=16, `PDM_I1_W`=20, `PDM_I2_W`=24, `PDM_FB_MAG`=32768;
  - a saturate function parameterised by width.
- Sub-module `pdm_dac_channel`:
  - contains x latch, two integrators and output flop;
  - inputs: `clk`, `rst`, `enable`, `tick`, `load`, `x_in`;
  - instantiated twice.
- Top `pdm_dac`: `div_cnt`/`tick` generation and channel wiring.

## Test plan
- DIV=1, x=0 both channels, after 64 settling ticks: count ones over 1024 cycles -> 512 ±2 per channel.
- `left_data`=0x400000 (x=+16384), `right_data`=0xC00000 (x=-16384) -> left ones 768 ±3, right ones 256 ±3 over 1024 ticks.
- x=+32767 held for 10000 ticks:
  - `i1`/`i2` never exceed positive clamp limits (no sign flip);
  - ones density ≥ 1023/1024;
  - after switching to x=0, density returns to 512 ±4/1024 within 200 ticks.
- DIV=4:
  - `pdm_*` changes only on cycles immediately after `div_cnt`==3;
  - `next_sample` coincident with `tick` -> that tick's output matches a model using the previous x.
- Assert `rst` for 1 cycle mid-stream -> next cycle all state and outputs are 0; first tick is DIV cycles later. Repeat with `enable`=0 -> outputs held 0, integrators 0 while `div_cnt` keeps counting.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the PDM modulator datapath.
// Widths are fixed so both channels and the bench agree on integrator ranges.
package audio_pkg;

    localparam int PDM_IN_W   = 16;
    localparam int PDM_I1_W   = 20;
    localparam int PDM_I2_W   = 24;
    localparam int PDM_FB_MAG = 32768;
    localparam int PDM_FB_W   = PDM_IN_W + 2;

    // Clamp a signed value into the two's-complement range of 'width' bits.
    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                                input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/pdm_dac_channel.sv
// One channel of the second-order delta-sigma modulator: sample latch,
// two saturating integrators and the registered 1-bit output.
module pdm_dac_channel
    import audio_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       tick,
    input  logic                       load,
    input  logic signed [PDM_IN_W-1:0] x_in,
    output logic                       pdm
);

    localparam int S1_W = PDM_I1_W + 1;
    localparam int S2_W = PDM_I2_W + 1;
    localparam logic signed [PDM_FB_W-1:0] FB_POS = PDM_FB_W'(PDM_FB_MAG);
    localparam logic signed [PDM_FB_W-1:0] FB_NEG = PDM_FB_W'(-PDM_FB_MAG);

    logic signed [PDM_IN_W-1:0] x;
    logic signed [PDM_I1_W-1:0] i1;
    logic signed [PDM_I2_W-1:0] i2;
    logic signed [PDM_FB_W-1:0] fb;
    logic signed [S1_W-1:0]     sum1;
    logic signed [S2_W-1:0]     sum2;
    logic signed [PDM_I1_W-1:0] i1_new;
    logic signed [PDM_I2_W-1:0] i2_new;

    // NOTE: every variable gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        fb     = pdm ? FB_POS : FB_NEG;
        sum1   = S1_W'(i1) + S1_W'(x) - S1_W'(fb);
        i1_new = PDM_I1_W'(sat(32'(sum1), PDM_I1_W));
        sum2   = S2_W'(i2) + S2_W'(i1_new) - S2_W'(fb);
        i2_new = PDM_I2_W'(sat(32'(sum2), PDM_I2_W));
    end

    // The latch uses the pre-edge x, so a strobe coinciding with a tick only affects later ticks.
    // NOTE: non-blocking assignments make every register see pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            x   <= '0;
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
        end else begin
            if (load) begin
                x <= x_in;
            end
            if (!enable) begin
                i1  <= '0;
                i2  <= '0;
                pdm <= 1'b0;
            end else if (tick) begin
                i1  <= i1_new;
                i2  <= i2_new;
                pdm <= ~i2_new[PDM_I2_W-1];
            end
        end
    end

endmodule

// File: rtl/pdm_dac.sv
// Stereo PDM DAC: shared update-rate divider feeding two identical
// delta-sigma channels driven from the mixer's 24-bit sample words.
module pdm_dac
    import audio_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        enable,
    input  logic        next_sample,
    input  logic [23:0] left_data,
    input  logic [23:0] right_data,
    output logic        pdm_left,
    output logic        pdm_right
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] div_cnt;
    logic       tick;
    logic       unused_lsbs;

    assign tick = (div_cnt == LAST);

    // Bits below the 16-bit modulator resolution are dropped.
    assign unused_lsbs = ^{left_data[7:0], right_data[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    pdm_dac_channel u_left (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick),
        .load   (next_sample),
        .x_in   (left_data[23:8]),
        .pdm    (pdm_left)
    );

    pdm_dac_channel u_right (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick),
        .load   (next_sample),
        .x_in   (right_data[23:8]),
        .pdm    (pdm_right)
    );

endmodule
